// File: rtl/sata_prims_pkg.sv
// SATA 10b character and primitive constants shared by the OOB/link models.
// Characters are written 'a' bit first (bit 9 = a ... bit 0 = j).
package sata_prims_pkg;

    localparam int P_BITS    = 40;
    localparam int CHAR_BITS = 10;

    localparam logic [9:0] K28_5 = 10'b0011111010;
    localparam logic [9:0] K28_3 = 10'b0011110011;
    localparam logic [9:0] D10_2 = 10'b0101010101;
    localparam logic [9:0] D21_2 = 10'b1010100101;
    localparam logic [9:0] D21_4 = 10'b1010101101;
    localparam logic [9:0] D21_5 = 10'b1010101010;
    localparam logic [9:0] D23_2 = 10'b1110100101;
    localparam logic [9:0] D27_3 = 10'b0010011100;

    // char0 sits in the low slice and goes out first
    localparam logic [39:0] ALIGN_P = {D27_3, D10_2, D10_2, K28_5};
    localparam logic [39:0] SYNC_P  = {D21_5, D21_5, D21_4, K28_3};
    localparam logic [39:0] X_RDY   = {D23_2, D23_2, D21_2, K28_3};
    localparam logic [39:0] R_RDY   = {D10_2, D10_2, D21_4, K28_3};

endpackage

// File: rtl/alignp_transmit.sv
// Serializes a 40-bit primitive one bit per clock onto a differential pair
// while burst_en is high; holds electrical idle (both low) otherwise.
// Ports: clk, reset (async, active-high), burst_en, data_p[P_BITS-1:0],
//        tx_p / tx_n (registered differential outputs).
module alignp_transmit #(
    parameter int P_BITS    = sata_prims_pkg::P_BITS,
    parameter int CHAR_BITS = sata_prims_pkg::CHAR_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              burst_en,
    input  logic [P_BITS-1:0] data_p,
    output logic              tx_p,
    output logic              tx_n
);

    localparam int IW = $clog2(P_BITS);

    logic [IW-1:0]     bit_idx;
    logic [P_BITS-1:0] frame_q;
    logic [P_BITS-1:0] src;
    logic [P_BITS-1:0] ordered;
    logic              cur_bit;

    // At index 0 the new primitive is sent straight from data_p while it
    // is being captured, so there is no extra cycle of latency.
    // ordered[k] is the k-th bit on the wire: characters low slice first,
    // each character MSB first.
    always_comb begin
        src = (bit_idx == '0) ? data_p : frame_q;
        ordered = '0;
        for (int k = 0; k < P_BITS; k++) begin
            ordered[k] = src[(k / CHAR_BITS) * CHAR_BITS
                             + CHAR_BITS - 1 - (k % CHAR_BITS)];
        end
        cur_bit = ordered[bit_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_idx <= '0;
            frame_q <= '0;
            tx_p    <= 1'b0;
            tx_n    <= 1'b0;
        end else if (burst_en) begin
            if (bit_idx == '0) begin
                frame_q <= data_p;
            end
            if (bit_idx == IW'(P_BITS - 1)) begin
                bit_idx <= '0;
            end else begin
                bit_idx <= bit_idx + IW'(1);
            end
            tx_p <= cur_bit;
            tx_n <= ~cur_bit;
        end else begin
            // truncate immediately; next burst restarts at char0 bit 0
            bit_idx <= '0;
            tx_p    <= 1'b0;
            tx_n    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alignp_transmit.sv
// Self-checking bench for alignp_transmit against a bit-stream model.
// Covers reset, streaming, wrap, burst shaping, mid-frame data change.
module tb_alignp_transmit;
    import sata_prims_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        burst_en = 1'b0;
    logic [39:0] data_p = '0;
    logic        tx_p;
    logic        tx_n;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_pos = 0;
    logic [39:0] m_frame = '0;

    alignp_transmit dut (
        .clk(clk),
        .reset(reset),
        .burst_en(burst_en),
        .data_p(data_p),
        .tx_p(tx_p),
        .tx_n(tx_n)
    );

    always #5 clk = ~clk;

    // Model: position within the current burst, snapshot of the primitive
    // at each frame start, and the wire order from the character rules.
    task automatic tick(output logic ep, output logic en);
        @(posedge clk);
        if (reset) begin
            m_pos = 0;
            m_frame = '0;
            ep = 1'b0;
            en = 1'b0;
        end else if (burst_en) begin
            if (m_pos == 0) m_frame = data_p;
            ep = m_frame[(m_pos / 10) * 10 + 9 - (m_pos % 10)];
            en = ~ep;
            m_pos = (m_pos + 1) % 40;
        end else begin
            m_pos = 0;
            ep = 1'b0;
            en = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        logic ep, en;
        reset = 1'b1;
        burst_en = 1'b1;
        data_p = ALIGN_P;
        for (int i = 0; i < 3; i++) begin
            tick(ep, en);
            n_cmp++;
            if ({tx_p, tx_n} !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_held: got %b%b want 00", tx_p, tx_n);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 7; i++) tick(ep, en);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({tx_p, tx_n} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_async: got %b%b want 00", tx_p, tx_n);
        end
        m_pos = 0;
        m_frame = '0;
        #1;
        reset = 1'b0;
        burst_en = 1'b0;
        tick(ep, en);
    endtask

    task automatic test_align_stream();
        logic ep, en;
        logic [39:0] want;
        want = 40'b0011111010_0101010101_0101010101_0010011100;
        data_p = ALIGN_P;
        burst_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(ep, en);
            n_cmp++;
            if (tx_p !== want[39 - i] || tx_n !== ~want[39 - i]) begin
                n_bad++;
                $display("FAIL align_bit%0d: got %b%b want %b%b",
                         i, tx_p, tx_n, want[39 - i], ~want[39 - i]);
            end
        end
        burst_en = 1'b0;
        tick(ep, en);
    endtask

    task automatic test_continuous();
        logic ep, en;
        logic [39:0] want;
        want = 40'b0011111010_0101010101_0101010101_0010011100;
        data_p = ALIGN_P;
        burst_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick(ep, en);
            n_cmp++;
            if (tx_p !== want[39 - (i % 40)] || tx_n !== ~tx_p) begin
                n_bad++;
                $display("FAIL cont_cyc%0d: got %b%b want %b",
                         i, tx_p, tx_n, want[39 - (i % 40)]);
            end
        end
        burst_en = 1'b0;
        tick(ep, en);
    endtask

    task automatic test_comwake();
        logic ep, en;
        data_p = ALIGN_P;
        for (int r = 0; r < 6; r++) begin
            burst_en = 1'b1;
            for (int i = 0; i < 160; i++) begin
                tick(ep, en);
                n_cmp++;
                if ({tx_p, tx_n} !== {ep, en}) begin
                    n_bad++;
                    $display("FAIL comwake_on r%0d c%0d: got %b%b want %b%b",
                             r, i, tx_p, tx_n, ep, en);
                end
                if (i == 0) begin
                    n_cmp++;
                    if (tx_p !== K28_5[9]) begin
                        n_bad++;
                        $display("FAIL comwake_first r%0d: got %b want %b",
                                 r, tx_p, K28_5[9]);
                    end
                end
            end
            burst_en = 1'b0;
            for (int i = 0; i < 160; i++) begin
                tick(ep, en);
                n_cmp++;
                if ({tx_p, tx_n} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL comwake_idle r%0d c%0d: got %b%b want 00",
                             r, i, tx_p, tx_n);
                end
            end
        end
    endtask

    task automatic test_switch_data();
        logic ep, en;
        logic [39:0] want;
        want = 40'b0011111010_0101010101_0101010101_0010011100;
        data_p = ALIGN_P;
        burst_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i == 17) data_p = SYNC_P;
            tick(ep, en);
            n_cmp++;
            if (i < 40) begin
                if (tx_p !== want[39 - i]) begin
                    n_bad++;
                    $display("FAIL switch_old b%0d: got %b want %b",
                             i, tx_p, want[39 - i]);
                end
            end else begin
                if (tx_p !== K28_3[49 - i]) begin
                    n_bad++;
                    $display("FAIL switch_new b%0d: got %b want %b",
                             i, tx_p, K28_3[49 - i]);
                end
            end
        end
        burst_en = 1'b0;
        tick(ep, en);
    endtask

    task automatic test_truncate();
        logic ep, en;
        data_p = ALIGN_P;
        burst_en = 1'b1;
        for (int i = 0; i < 35; i++) begin
            if (i == 25) burst_en = 1'b0;
            if (i == 28) burst_en = 1'b1;
            tick(ep, en);
            n_cmp++;
            if ({tx_p, tx_n} !== {ep, en} || (tx_p & tx_n)) begin
                n_bad++;
                $display("FAIL trunc_c%0d: got %b%b want %b%b",
                         i, tx_p, tx_n, ep, en);
            end
            if (i == 28) begin
                n_cmp++;
                if (tx_p !== K28_5[9]) begin
                    n_bad++;
                    $display("FAIL trunc_restart: got %b want %b",
                             tx_p, K28_5[9]);
                end
            end
        end
        burst_en = 1'b0;
        tick(ep, en);
    endtask

    task automatic test_toggle();
        logic ep, en;
        for (int i = 0; i < 40; i++) begin
            data_p = {$urandom, $urandom};
            burst_en = i[0];
            tick(ep, en);
            n_cmp++;
            if ({tx_p, tx_n} !== {ep, en}) begin
                n_bad++;
                $display("FAIL toggle_c%0d: got %b%b want %b%b",
                         i, tx_p, tx_n, ep, en);
            end
        end
    endtask

    task automatic test_random();
        logic ep, en;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) data_p = {$urandom, $urandom};
            if ($urandom_range(0, 60) == 0) burst_en = ~burst_en;
            tick(ep, en);
            n_cmp++;
            if ({tx_p, tx_n} !== {ep, en} || (tx_p & tx_n)) begin
                n_bad++;
                $display("FAIL random_c%0d: got %b%b want %b%b",
                         i, tx_p, tx_n, ep, en);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_align_stream();
        test_continuous();
        test_comwake();
        test_switch_data();
        test_truncate();
        test_toggle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
